display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display scanner. Successor to the fixed 8-digit scanner used by the cronometer.
- Adds:
  - configurable digit count and scan rate
  - PWM brightness
  - per-digit blanking and blinking
  - leading-zero suppression
  - selectable output polarity
  - frame-start pulse
- Sits between the timekeeping/BCD logic and the board segment/anode pins.

Parameters:
- N_DIGITS, 8: number of digits scanned; must be >= 2.
- SCAN_LOG2, 17: each digit slot lasts 2**SCAN_LOG2 clocks.
- BRIGHT_W, 3: brightness input width; must be <= SCAN_LOG2.
- BLINK_LOG2, 6: blink phase toggles every 2**BLINK_LOG2 full frames.
- SEG_ACT_LOW, 1: 1 = a lit segment drives 0 on seg.
- DSP_ACT_LOW, 0: 1 = the selected digit drives 0 on dsp.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  0 = all digits dark; scanning continues
- value  in  N_DIGITS x 4  hex nibble per digit; digit 0 is rightmost
- dot  in  N_DIGITS  decimal point per digit
- blank_mask  in  N_DIGITS  1 = digit forced dark (segments and dot)
- blink_mask  in  N_DIGITS  1 = digit dark during blink-off phase
- lz_blank  in  1  1 = suppress leading zeros
- brightness  in  BRIGHT_W  duty select; 0 = minimum, all-ones = full
- seg  out  8  {dp,g,f,e,d,c,b,a}, registered
- dsp  out  N_DIGITS  one-hot digit select, registered
- frame_tick  out  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Reset (rst=1 at a clk edge, also mid-operation):
  - slot counter=0, index=0, blink phase=0 (visible)
  - seg=all segments unlit (respecting SEG_ACT_LOW)
  - dsp=no digit selected (respecting DSP_ACT_LOW)
  - frame_tick=0
  - No output glitch other than going dark.
- Slot counter: SCAN_LOG2-bit free-running counter; wraps naturally.
- Update: occurs in every cycle where the slot counter = 0, including the first cycle after reset release.
  - Index register: advances after the update; wraps N_DIGITS-1 -> 0.
- Latency: outputs for the new digit appear one clock after the update cycle. Digit i is therefore shown from cycle 1 after reset release, for 2**SCAN_LOG2 clocks. Scan order is 0,1,...,N_DIGITS-1.
- seg sampling: seg is loaded once per slot from value, dot and the masks sampled in the update cycle. It holds for the whole slot.
- Glyphs: standard hex, gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Dark digit (segments a-g and dp all unlit): any of
  - blank_mask[i]
  - blink_mask[i] while blink phase=1
- Leading-zero suppression: when lz_blank=1, digit i>0 has a-g unlit if value[j]==0 for all j>=i. Digit 0 is never suppressed. dp still follows dot[i].
- PWM: let k = cycles since the digit appeared (0..2**SCAN_LOG2-1) and phase = k >> (SCAN_LOG2-BRIGHT_W).
  - dsp selects digit i iff en=1 and phase <= brightness; otherwise no digit is selected.
  - brightness and en are sampled every cycle; a change is reflected on dsp one clock later.
- Blink:
  - frame counter: BLINK_LOG2 bits; increments on each index wrap N_DIGITS-1 -> 0.
  - blink phase: toggles when the frame counter wraps.
- frame_tick: 1 in exactly the first cycle that digit 0's outputs are presented.
- Width rules:
  - index: $clog2(N_DIGITS) bits; N_DIGITS need not be a power of two (wrap is explicit).
  - All counters wrap silently.

Test Plan:
All scenarios use N_DIGITS=4, SCAN_LOG2=4, BRIGHT_W=2, BLINK_LOG2=1, SEG_ACT_LOW=1, DSP_ACT_LOW=0.
1. Basic scan:
   - Stimulus: reset release, en=1, brightness=3, value={3,2,1,0}, all masks 0.
   - Cycle 1: dsp=0001, seg=8'b1100_0000, frame_tick=1.
   - Cycle 17: dsp=0010, seg=8'b1111_1001.
   - frame_tick again at cycle 65.
2. PWM:
   - Stimulus: brightness=0.
   - dsp active for k=0..3 and 0000 for k=4..15 of each slot; seg constant across the slot.
   - brightness=2: active for k=0..11.
3. Leading zeros:
   - Stimulus: value={0,0,7,0}, lz_blank=1, dot[3]=1.
   - digit3 seg=8'b0111_1111 (only dp lit); digit2 seg=8'hFF.
   - digit1 shows 7 (8'b1111_1000); digit0 shows 0 (8'b1100_0000).
4. Blink/blank:
   - Stimulus: blink_mask=0010, blank_mask=1000.
   - digit1 lit in frames 0-1, seg=8'hFF in frames 2-3, lit again in frames 4-5.
   - digit3 always seg=8'hFF.
5. Reset mid-slot and en:
   - Stimulus: assert rst at k=7 of digit 2.
   - Next cycle: dsp=0000, seg=8'hFF. After release: restart at digit 0 on cycle 1.
   - Separately, en=0 for 5 cycles: dsp=0000 during those cycles, index advance unaffected.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment display scanner with PWM brightness, per-digit
// blanking/blinking, leading-zero suppression and selectable pin polarity.
module display_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int SCAN_LOG2   = 17,
  parameter int BRIGHT_W    = 3,
  parameter int BLINK_LOG2  = 6,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DSP_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_DIGITS*4-1:0] value,
  input  logic [N_DIGITS-1:0]   dot,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   dsp,
  output logic                  frame_tick
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [SCAN_LOG2-1:0]  slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      cur_idx_p1;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  blink_ph;

  logic                  update;
  logic                  idx_wrap;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic                  lz_supp;
  logic                  dark;
  logic [7:0]            seg_lit;
  logic [IDX_W-1:0]      dsp_digit;
  logic                  dsp_on;
  logic [N_DIGITS-1:0]   dsp_lit;

  // Hex glyph in gfedcba order, 1 = segment lit.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Map logical "lit" pattern to pin levels.
  function automatic logic [7:0] seg_drive(input logic [7:0] lit);
    seg_drive = SEG_ACT_LOW ? ~lit : lit;
  endfunction

  function automatic logic [N_DIGITS-1:0] dsp_drive(input logic [N_DIGITS-1:0] sel);
    dsp_drive = DSP_ACT_LOW ? ~sel : sel;
  endfunction

  assign update   = (slot_cnt == '0);
  assign idx_wrap = update && (idx == LAST_IDX);

  // Slot counter, digit index and blink phase bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + SCAN_LOG2'(1);
      if (update) idx <= idx_wrap ? '0 : idx + IDX_W'(1);
      if (idx_wrap) begin
        frame_cnt <= frame_cnt + BLINK_LOG2'(1);
        if (frame_cnt == '1) blink_ph <= ~blink_ph;
      end
    end
  end

  // Stage p0: segment pattern for the digit being loaded this update.
  always_comb begin
    nib      = value[{idx, 2'b00} +: 4];
    upper_nz = 1'b0;
    for (int j = 0; j < N_DIGITS; j++)
      if (j >= int'(idx) && value[j*4 +: 4] != 4'h0) upper_nz = 1'b1;
    lz_supp  = lz_blank && (idx != '0) && !upper_nz;
    dark     = blank_mask[idx] || (blink_mask[idx] && blink_ph);
    seg_lit  = '0;
    if (!dark) seg_lit = {dot[idx], lz_supp ? 7'h00 : glyph(nib)};
  end

  // Stage p0: digit select; the update cycle already refers to the new digit.
  always_comb begin
    dsp_digit = update ? idx : cur_idx_p1;
    dsp_on    = en && (slot_cnt[SCAN_LOG2-1 -: BRIGHT_W] <= brightness);
    dsp_lit   = dsp_on ? (N_DIGITS'(1) << dsp_digit) : '0;
  end

  // Stage p1: remember which digit the current slot shows.
  always_ff @(posedge clk) begin
    if (update) cur_idx_p1 <= idx;
  end

  // Stage p1: registered pin outputs; reset drives everything dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= seg_drive(8'h00);
      dsp        <= dsp_drive('0);
      frame_tick <= 1'b0;
    end else begin
      if (update) seg <= seg_drive(seg_lit);
      dsp        <= dsp_drive(dsp_lit);
      frame_tick <= update && (idx == '0);
    end
  end

endmodule
